// File: rtl/pi_pkg.sv
// Shared types for the EBOX priority-interrupt arbiter.
package pi_pkg;
  typedef bit [1:7] pi_mask_t;
  typedef bit [0:2] pi_level_t;

  localparam pi_level_t PI_NONE = 3'd0;
endpackage

// File: rtl/pi_prio_enc.sv
// Lowest-numbered-set-bit encoder over a seven-level PI mask.
module pi_prio_enc
  import pi_pkg::*;
(
  input  logic [1:7] i_mask,
  output logic       o_valid,
  output logic [0:2] o_level
);

  // Scan from level 7 down so the lowest-numbered set bit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_level = PI_NONE;
    for (int unsigned i = 7; i >= 1; i--) begin
      if (i_mask[i]) begin
        o_valid = 1'b1;
        o_level = 3'(i);
      end
    end
  end

endmodule

// File: rtl/pi_arbiter.sv
// Seven-level priority-interrupt arbiter: PIO/PIR/PIH state plus registered grant
// feeding the downstream 3-to-8 level decoder.
module pi_arbiter
  import pi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:7] dev_req,
  input  logic [1:7] lvl_sel,
  input  logic       lvl_on,
  input  logic       lvl_off,
  input  logic       init_req,
  input  logic       drop_req,
  input  logic       sys_on,
  input  logic       sys_off,
  input  logic       sys_clear,
  input  logic       take,
  input  logic       dismiss,
  output logic       pi_en,
  output logic [0:2] pi_sel,
  output logic [1:7] pio,
  output logic [1:7] pir,
  output logic [1:7] pih,
  output logic       active
);

  logic [1:7] r_pio, r_pir, r_pih;
  logic       r_active;
  logic       r_pi_en;
  logic [0:2] r_pi_sel;

  logic [1:7] w_pio_nx, w_pir_nx, w_pih_nx;
  logic       w_active_nx;
  logic       w_hold_valid;
  logic [0:2] w_hold_lvl;
  logic [1:7] w_cand_mask;
  logic       w_cand_valid;
  logic [0:2] w_cand_lvl;

  pi_prio_enc u_hold_enc (
    .i_mask  (r_pih),
    .o_valid (w_hold_valid),
    .o_level (w_hold_lvl)
  );

  // Ordered update: CONO, then dismiss, then take; sys_clear overrides all.
  always_comb begin
    w_pio_nx    = (r_pio | (lvl_on   ? lvl_sel : '0)) & ~(lvl_off  ? lvl_sel : '0);
    w_pir_nx    = (r_pir | (init_req ? lvl_sel : '0)) & ~(drop_req ? lvl_sel : '0);
    w_pih_nx    = r_pih;
    w_active_nx = sys_off ? 1'b0 : (sys_on ? 1'b1 : r_active);
    for (int unsigned i = 1; i <= 7; i++) begin
      if (dismiss && w_hold_valid && (w_hold_lvl == 3'(i)))
        w_pih_nx[i] = 1'b0;
    end
    for (int unsigned i = 1; i <= 7; i++) begin
      if (take && r_pi_en && (r_pi_sel == 3'(i))) begin
        w_pih_nx[i] = 1'b1;
        w_pir_nx[i] = 1'b0;
      end
    end
    if (sys_clear) begin
      w_pio_nx    = '0;
      w_pir_nx    = '0;
      w_pih_nx    = '0;
      w_active_nx = 1'b0;
    end
  end

  // A held level masks itself and every lower-priority level.
  always_comb begin
    logic blocked;
    blocked     = 1'b0;
    w_cand_mask = '0;
    for (int unsigned i = 1; i <= 7; i++) begin
      blocked        = blocked | w_pih_nx[i];
      w_cand_mask[i] = w_active_nx & ((dev_req[i] & w_pio_nx[i]) | w_pir_nx[i]) & ~blocked;
    end
  end

  pi_prio_enc u_cand_enc (
    .i_mask  (w_cand_mask),
    .o_valid (w_cand_valid),
    .o_level (w_cand_lvl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pio    <= '0;
      r_pir    <= '0;
      r_pih    <= '0;
      r_active <= 1'b0;
      r_pi_en  <= 1'b0;
      r_pi_sel <= PI_NONE;
    end else begin
      r_pio    <= w_pio_nx;
      r_pir    <= w_pir_nx;
      r_pih    <= w_pih_nx;
      r_active <= w_active_nx;
      r_pi_en  <= w_cand_valid;
      r_pi_sel <= w_cand_valid ? w_cand_lvl : PI_NONE;
    end
  end

  assign pio    = r_pio;
  assign pir    = r_pir;
  assign pih    = r_pih;
  assign active = r_active;
  assign pi_en  = r_pi_en;
  assign pi_sel = r_pi_sel;

endmodule

// File: tb/tb_pi_arbiter.sv
// Self-checking bench for pi_arbiter: per-scenario step tables, expected state
// queued on drive and compared after the edge.
module tb_pi_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:7] dev_req, lvl_sel;
  logic       lvl_on, lvl_off, init_req, drop_req;
  logic       sys_on, sys_off, sys_clear, take, dismiss;
  logic       pi_en, active;
  logic [0:2] pi_sel;
  logic [1:7] pio, pir, pih;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] OP_ON   = 9'h001, OP_OFF  = 9'h002, OP_INIT = 9'h004,
                         OP_DROP = 9'h008, OP_SON  = 9'h010, OP_SOFF = 9'h020,
                         OP_CLR  = 9'h040, OP_TAKE = 9'h080, OP_DISM = 9'h100;

  typedef struct {
    string       name;
    logic [1:7]  dev;
    logic [1:7]  sel;
    logic [8:0]  ops;
    logic [25:0] exp;
  } step_t;

  logic [25:0] sb[$];

  pi_arbiter dut (
    .clk(clk), .rst_n(rst_n), .dev_req(dev_req), .lvl_sel(lvl_sel),
    .lvl_on(lvl_on), .lvl_off(lvl_off), .init_req(init_req), .drop_req(drop_req),
    .sys_on(sys_on), .sys_off(sys_off), .sys_clear(sys_clear), .take(take),
    .dismiss(dismiss), .pi_en(pi_en), .pi_sel(pi_sel), .pio(pio), .pir(pir),
    .pih(pih), .active(active)
  );

  always #5 clk = ~clk;

  function automatic logic [1:7] lv(input int l);
    logic [1:7] m;
    m    = '0;
    m[l] = 1'b1;
    return m;
  endfunction

  function automatic logic [25:0] expv(input logic a, input logic [1:7] o, input logic [1:7] r,
                                       input logic [1:7] h, input logic e, input int s);
    logic [2:0] s3;
    s3 = s[2:0];
    return {a, o, r, h, e, s3};
  endfunction

  function automatic logic [25:0] obs();
    return {active, pio, pir, pih, pi_en, pi_sel};
  endfunction

  function automatic step_t mk(input string n, input logic [1:7] d, input logic [1:7] s,
                               input logic [8:0] ops, input logic [25:0] e);
    step_t t;
    t.name = n; t.dev = d; t.sel = s; t.ops = ops; t.exp = e;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input step_t s);
    dev_req   = s.dev;
    lvl_sel   = s.sel;
    lvl_on    = s.ops[0];
    lvl_off   = s.ops[1];
    init_req  = s.ops[2];
    drop_req  = s.ops[3];
    sys_on    = s.ops[4];
    sys_off   = s.ops[5];
    sys_clear = s.ops[6];
    take      = s.ops[7];
    dismiss   = s.ops[8];
    sb.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [25:0] e;
    apply(mk("idle", '0, '0, '0, '0));
    void'(sb.pop_front());
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 26'h0) begin
      $display("FAIL reset_async: got %h expected %h", obs(), 26'h0);
      n_fail++;
    end
    apply(mk("in_reset", lv(3), lv(3), OP_ON | OP_SON | OP_INIT, '0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e) begin
      $display("FAIL in_reset: got %h expected %h", obs(), e);
      n_fail++;
    end
    apply(mk("idle", '0, '0, '0, '0));
    void'(sb.pop_front());
    #4 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step_t s[$];
    logic [25:0] e;
    s.push_back(mk("enable", '0, lv(3), OP_ON | OP_SON, expv(1, lv(3), 0, 0, 0, 0)));
    s.push_back(mk("grant3", lv(3), '0, '0, expv(1, lv(3), 0, 0, 1, 3)));
    s.push_back(mk("hold3", lv(3), '0, '0, expv(1, lv(3), 0, 0, 1, 3)));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    logic [25:0] e;
    logic [1:7] p35;
    p35 = lv(3) | lv(5);
    s.push_back(mk("en5", p35, lv(5), OP_ON, expv(1, p35, 0, 0, 1, 3)));
    s.push_back(mk("take3", p35, '0, OP_TAKE, expv(1, p35, 0, lv(3), 0, 0)));
    s.push_back(mk("held3", lv(5), '0, '0, expv(1, p35, 0, lv(3), 0, 0)));
    s.push_back(mk("dism3", lv(5), '0, OP_DISM, expv(1, p35, 0, 0, 1, 5)));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_preempt();
    step_t s[$];
    logic [25:0] e;
    logic [1:7] p35, p235;
    p35  = lv(3) | lv(5);
    p235 = lv(2) | p35;
    s.push_back(mk("take5", lv(5), '0, OP_TAKE, expv(1, p35, 0, lv(5), 0, 0)));
    s.push_back(mk("pre2", lv(2) | lv(5), lv(2), OP_ON, expv(1, p235, 0, lv(5), 1, 2)));
    s.push_back(mk("wdraw2", lv(5), '0, '0, expv(1, p235, 0, lv(5), 0, 0)));
    s.push_back(mk("low6", lv(5) | lv(6), lv(6), OP_ON, expv(1, p235 | lv(6), 0, lv(5), 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    logic [25:0] e;
    logic [1:7] p;
    p = lv(2) | lv(3) | lv(5) | lv(6);
    s.push_back(mk("regr2", lv(2) | lv(5), '0, '0, expv(1, p, 0, lv(5), 1, 2)));
    s.push_back(mk("take_dism", lv(2) | lv(5), '0, OP_TAKE | OP_DISM, expv(1, p, 0, lv(2), 0, 0)));
    s.push_back(mk("dism2", lv(5), '0, OP_DISM, expv(1, p, 0, 0, 1, 5)));
    s.push_back(mk("clr_take", lv(5), lv(1), OP_CLR | OP_TAKE | OP_SON | OP_ON | OP_INIT, '0));
    s.push_back(mk("on_off", lv(4), lv(4), OP_SON | OP_ON | OP_OFF | OP_INIT | OP_DROP,
                   expv(1, 0, 0, 0, 0, 0)));
    s.push_back(mk("son_soff", lv(4), '0, OP_SON | OP_SOFF, '0));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_program();
    step_t s[$];
    logic [25:0] e;
    s.push_back(mk("pir_inactive", '0, lv(4), OP_INIT, expv(0, 0, lv(4), 0, 0, 0)));
    s.push_back(mk("pir_active", '0, '0, OP_SON, expv(1, 0, lv(4), 0, 1, 4)));
    s.push_back(mk("pir_take", '0, '0, OP_TAKE, expv(1, 0, 0, lv(4), 0, 0)));
    s.push_back(mk("pir_dism", '0, '0, OP_DISM, expv(1, 0, 0, 0, 0, 0)));
    s.push_back(mk("pir_again", '0, lv(4), OP_INIT, expv(1, 0, lv(4), 0, 1, 4)));
    s.push_back(mk("sys_off", '0, '0, OP_SOFF, expv(0, 0, lv(4), 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [25:0] e;
    s.push_back(mk("grant1", lv(1), lv(1), OP_SON | OP_ON, expv(1, lv(1), lv(4), 0, 1, 1)));
    s.push_back(mk("wdraw_take", '0, '0, OP_TAKE, expv(1, lv(1), lv(4), lv(1), 0, 0)));
    s.push_back(mk("dism1", '0, '0, OP_DISM, expv(1, lv(1), lv(4), 0, 1, 4)));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        $display("FAIL %s: got %h expected %h", s[i].name, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] e;
    apply(mk("idle", '0, '0, '0, '0));
    void'(sb.pop_front());
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 26'h0) begin
      $display("FAIL mid_grant_reset: got %h expected %h", obs(), 26'h0);
      n_fail++;
    end
    #5 rst_n = 1'b1;
    apply(mk("take_idle", '0, '0, OP_TAKE, '0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e) begin
      $display("FAIL take_idle: got %h expected %h", obs(), e);
      n_fail++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_preempt();
    test_simultaneous();
    test_program();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pi_arbiter.md
# pi_arbiter

- Seven-level priority-interrupt arbiter for the EBOX.
- Holds per-level enable (PIO), program-request (PIR) and in-progress hold (PIH) state, and combines these with device request lines.
- Registers the winning level as an enable plus 3-bit level number, which drives the 3-to-8 level decoder directly downstream. That decoder turns the result into one-hot level strobes for the interrupt-fetch logic.
- Level 1 is highest priority, level 7 lowest; level 0 is never granted.

## Interface

Parameters: none.

- `clk`  in  1  EBOX clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `dev_req`  in  [1:7]  device interrupt requests, level-sensitive, synchronous to `clk`
- `lvl_sel`  in  [1:7]  level mask for the CONO operations below
- `lvl_on`  in  1  set PIO bits in `lvl_sel`
- `lvl_off`  in  1  clear PIO bits in `lvl_sel`
- `init_req`  in  1  set PIR bits in `lvl_sel`
- `drop_req`  in  1  clear PIR bits in `lvl_sel`
- `sys_on`  in  1  set `active`
- `sys_off`  in  1  clear `active`
- `sys_clear`  in  1  clear PIO, PIR, PIH and `active`
- `take`  in  1  CPU accepts the currently granted level
- `dismiss`  in  1  CPU dismisses (JEN) the highest-priority held level
- `pi_en`  out  1  a level is granted (decoder `en`)
- `pi_sel`  out  [0:2]  granted level number 1..7; 0 when `pi_en`=0 (decoder `sel`)
- `pio`, `pir`, `pih`  out  [1:7]  state registers, for CONI
- `active`  out  1  PI system on

## Operation

Reset (`rst_n`=0, asynchronous): `pio`, `pir`, `pih`, `active`, `pi_en` and `pi_sel` all 0.

Effective request:
- `eff[L] = active & ((dev_req[L] & pio[L]) | pir[L])`.
- Program requests bypass PIO but still require `active`.

Candidate:
- The lowest-numbered L with `eff[L]`=1, such that no `pih[k]` is set for any k ≤ L.
- No candidate means no grant.

Per-cycle update order, applied to PIO/PIR/PIH/active:
1. `sys_clear`. This overrides every other input in the same cycle.
2. CONO operations:
   - set and clear requested together on the same bit: clear wins;
   - `sys_off` beats `sys_on`.
3. `dismiss`: clears the lowest-numbered set PIH bit. It is a no-op if PIH=0.
4. `take`: only when `pi_en`=1.
   - sets `pih[pi_sel]` and clears `pir[pi_sel]`;
   - `take` with `pi_en`=0 is ignored.

Grant registers:
- Load from the candidate computed on the post-update state.
- Consequently a taken level never re-grants on the following cycle, and a newly dismissed level's pending request regrants immediately.

## Timing

- Request to grant: 1 cycle. `dev_req`/PIR/PIO change at edge N → `pi_en`/`pi_sel` valid after edge N+1.
- Outputs are registered only; no combinational path from any input to `pi_en`/`pi_sel`.
- `take` at edge N:
  - PIH set at N;
  - `pi_en`/`pi_sel` at N reflect the next candidate (higher level only if one is requesting).
- `take` and `dismiss` in the same cycle:
  - dismiss clears the previously held level first;
  - take then holds the granted level.
- Dropping `dev_req` before `take` withdraws the grant one cycle later. A `take` in the same cycle as the withdrawal still completes, because it acts on the registered `pi_sel`.
- `sys_clear` or `sys_off` drops `pi_en` at the next edge.
- Reset mid-grant clears everything immediately, regardless of the clock.

## Structure

- Package `pi_pkg`:
  - `typedef bit [1:7] pi_mask_t;`
  - `typedef bit [0:2] pi_level_t;`
  - constant `PI_NONE` = 3'd0.
- Sub-module `pi_prio_enc`: combinational; takes a `pi_mask_t` and returns `valid` plus the lowest-numbered set bit as `pi_level_t`.
  - Used for candidate selection.
  - Used for dismiss selection (applied to PIH).
  - Holds-below masking is done in `pi_arbiter`.
- Estimated size: about 150–200 lines of RTL.

## Test plan

1. **Reset and basic grant.** Reset, then `sys_on`, `lvl_on` with `lvl_sel`=7'b0010000 (level 3), `dev_req[3]`=1 → `pi_en`=1, `pi_sel`=3 one cycle later; all outputs 0 during reset.
2. **Priority and hold.** Levels 3 and 5 requesting → grant 3. `take` → `pih`=level 3 and no grant for 5 while 3 is held. `dismiss` → `pi_sel`=5 next cycle.
3. **Preemption.** Level 5 held; raise `dev_req[2]` with PIO[2]=1 → grant 2. Raise level 6 instead → no grant.
4. **Program request.** `init_req` on level 4 with PIO[4]=0 and `active`=1 → grant 4. `take` clears `pir[4]` and sets `pih[4]`. With `active`=0 → no grant.
5. **Simultaneous events.**
   - `take` (level 2) plus `dismiss` with PIH = level 5 → `pih` = level 2 only.
   - `lvl_on` + `lvl_off` on the same bit → PIO bit clear.
   - `sys_clear` with a pending `take` → all state 0.
6. **Asynchronous reset mid-grant.** Assert `rst_n`=0 between clock edges while `pi_en`=1 → `pi_en`, `pi_sel`, and all masks go to 0 immediately.
